// File: rtl/quad_step_decoder_if.sv
// Signal bundle between a quadrature source and quad_step_decoder: raw phases and
// error clear in, step pulse / direction / sticky error out.
interface quad_step_decoder_if;
    logic a_in;
    logic b_in;
    logic clr_err;
    logic step_en;
    logic step_up;
    logic err;

    modport master (
        output a_in, b_in, clr_err,
        input  step_en, step_up, err
    );

    modport slave (
        input  a_in, b_in, clr_err,
        output step_en, step_up, err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise, glitch-filter and decode Gray transitions into
// single-cycle step pulses with direction, plus a sticky illegal-transition flag.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int RES         = 4
) (
    input  logic                clk,
    input  logic                rst,
    quad_step_decoder_if.slave  bus
);

    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic {
        UNPRIMED,
        PRIMED
    } prime_state_t;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             s_ab;
    logic [1:0]             f_ab;
    logic [1:0]             p_ab;
    logic [CW-1:0]          filt_cnt [2];

    prime_state_t state_q;
    prime_state_t state_d;
    logic         step_en_q;
    logic         step_en_d;
    logic         step_up_q;
    logic         step_up_d;
    logic         err_q;
    logic         err_d;

    logic moved;
    logic both_moved;
    logic is_up;
    logic gate;

    // Next position along the up sequence 00 -> 10 -> 11 -> 01 -> 00, bit 1 = A.
    function automatic logic [1:0] up_next(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.a_in};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.b_in};
        end
    end

    assign s_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // A phase only moves after disagreeing with its filtered value for FILT_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_ab <= '0;
            for (int i = 0; i < 2; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_ab[i] == f_ab[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == CW'(FILT_LEN - 1)) begin
                    f_ab[i]     <= s_ab[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign moved      = (f_ab != p_ab);
    assign both_moved = &(f_ab ^ p_ab);
    assign is_up      = (f_ab == up_next(p_ab));

    // Reduced resolutions only count B edges (and for RES=1 only those with A low),
    // so up and down steps land on the same positions.
    always_comb begin
        gate = 1'b1;
        if (RES == 2) begin
            gate = f_ab[0] ^ p_ab[0];
        end else if (RES == 1) begin
            gate = (f_ab[0] ^ p_ab[0]) & ~f_ab[1] & ~p_ab[1];
        end
    end

    // Clear is applied first so a same-cycle illegal transition re-sets err.
    always_comb begin
        state_d   = state_q;
        step_en_d = 1'b0;
        step_up_d = step_up_q;
        err_d     = err_q;
        if (bus.clr_err) begin
            err_d = 1'b0;
        end
        case (state_q)
            UNPRIMED: begin
                if (moved) begin
                    state_d = PRIMED;
                end
            end
            PRIMED: begin
                if (both_moved) begin
                    err_d = 1'b1;
                end else if (moved && gate) begin
                    step_en_d = 1'b1;
                    step_up_d = is_up;
                end
            end
            default: state_d = UNPRIMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UNPRIMED;
            p_ab      <= '0;
            step_en_q <= 1'b0;
            step_up_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_ab      <= f_ab;
            step_en_q <= step_en_d;
            step_up_q <= step_up_d;
            err_q     <= err_d;
        end
    end

    assign bus.step_en = step_en_q;
    assign bus.step_up = step_up_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: default-resolution and RES=1 instances, with a step
// scoreboard, a downstream 8-bit counter model and table-driven input sequences.
module tb_quad_step_decoder;

    localparam int LAT  = 7;
    localparam int HOLD = 10;

    typedef struct {
        logic a;
        logic b;
        logic exp_step;
        logic exp_up;
        logic exp_err;
    } vec_t;

    typedef struct {
        logic up;
        int   cycle;
    } exp_t;

    logic clk;
    logic rst4;
    logic rst1;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    logic cnt_clear;
    logic [7:0] count;

    exp_t q4[$];
    exp_t q1[$];
    vec_t tab4[11];
    vec_t tab1[17];

    quad_step_decoder_if bus4();
    quad_step_decoder_if bus1();

    quad_step_decoder dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    quad_step_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .RES(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream up/down counter fed by the default instance.
    always @(posedge clk) begin
        if (cnt_clear) begin
            count <= 8'd0;
        end else if (bus4.step_en) begin
            count <= count + (bus4.step_up ? 8'd1 : 8'hFF);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic a, input logic b,
                                 input logic exp_step, input logic exp_up);
        exp_t e;
        e.up    = exp_up;
        e.cycle = cyc + LAT;
        if (sel == 4) begin
            bus4.a_in = a;
            bus4.b_in = b;
            if (exp_step) q4.push_back(e);
        end else begin
            bus1.a_in = a;
            bus1.b_in = b;
            if (exp_step) q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst4 && bus4.step_en) begin
            if (q4.size() == 0) begin
                checkOutput("res4 unexpected step", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                checkOutput("res4 step_up", int'(bus4.step_up), int'(e.up));
                checkOutput("res4 step cycle", cyc, e.cycle);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && bus1.step_en) begin
            if (q1.size() == 0) begin
                checkOutput("res1 unexpected step", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                checkOutput("res1 step_up", int'(bus1.step_up), int'(e.up));
                checkOutput("res1 step cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        // prime, then up sequence, down sequence, illegal 00 -> 11
        tab4[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab4[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab4[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tab4[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tab4[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tab4[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab4[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab4[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tab4[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab4[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab4[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        // RES=1: prime, full up, full down, then set up step_up=1 / err=1
        tab1[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab1[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab1[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab1[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab1[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab1[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab1[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab1[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab1[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab1[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab1[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst4 = 1'b1;
        rst1 = 1'b1;
        cnt_clear = 1'b1;
        bus4.a_in = 1'b0; bus4.b_in = 1'b0; bus4.clr_err = 1'b0;
        bus1.a_in = 1'b0; bus1.b_in = 1'b0; bus1.clr_err = 1'b0;
        tick(3);
        rst4 = 1'b0;
        rst1 = 1'b0;
        cnt_clear = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput("reset step_en", int'(bus4.step_en), 0);
            checkOutput("reset step_up", int'(bus4.step_up), 0);
            checkOutput("reset err", int'(bus4.err), 0);
        end

        for (int i = 0; i < 11; i++) begin
            if (i == 2 || i == 6) begin
                cnt_clear = 1'b1;
                tick(1);
                cnt_clear = 1'b0;
            end
            applyStimulus(4, tab4[i].a, tab4[i].b, tab4[i].exp_step, tab4[i].exp_up);
            tick(HOLD);
            checkOutput("res4 err", int'(bus4.err), int'(tab4[i].exp_err));
            checkOutput("res4 pending steps", q4.size(), 0);
            if (i == 5) checkOutput("counter after up", int'(count), 4);
            if (i == 9) checkOutput("counter after down", int'(count), 8'hFC);
            if (i == 9) begin
                // 3-cycle glitch is swallowed; 4-cycle pulse gives up then down
                applyStimulus(4, 1'b1, 1'b0, 1'b0, 1'b0);
                tick(3);
                applyStimulus(4, 1'b0, 1'b0, 1'b0, 1'b0);
                tick(12);
                checkOutput("glitch3 pending steps", q4.size(), 0);
                checkOutput("glitch3 err", int'(bus4.err), 0);
                applyStimulus(4, 1'b1, 1'b0, 1'b1, 1'b1);
                tick(4);
                applyStimulus(4, 1'b0, 1'b0, 1'b1, 1'b0);
                tick(12);
                checkOutput("glitch4 pending steps", q4.size(), 0);
                checkOutput("glitch4 err", int'(bus4.err), 0);
            end
        end

        bus4.clr_err = 1'b1;
        tick(1);
        bus4.clr_err = 1'b0;
        checkOutput("err after clr", int'(bus4.err), 0);

        // second illegal (11 -> 00) lands on the same edge as clr_err
        applyStimulus(4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(LAT - 1);
        bus4.clr_err = 1'b1;
        tick(1);
        bus4.clr_err = 1'b0;
        checkOutput("err set beats clr", int'(bus4.err), 1);
        tick(HOLD);
        checkOutput("err still sticky", int'(bus4.err), 1);
        checkOutput("res4 pending after illegal", q4.size(), 0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, tab1[i].a, tab1[i].b, tab1[i].exp_step, tab1[i].exp_up);
            tick(HOLD);
            checkOutput("res1 err", int'(bus1.err), int'(tab1[i].exp_err));
            checkOutput("res1 pending steps", q1.size(), 0);
        end
        checkOutput("res1 step_up before rst", int'(bus1.step_up), 1);

        // a down step is in flight when reset hits; it must never appear
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(4);
        rst1 = 1'b1;
        #1;
        checkOutput("midrst step_en", int'(bus1.step_en), 0);
        checkOutput("midrst step_up", int'(bus1.step_up), 0);
        checkOutput("midrst err", int'(bus1.err), 0);
        tick(2);
        rst1 = 1'b0;
        tick(15);
        checkOutput("reprime no step", q1.size(), 0);
        checkOutput("reprime step_up", int'(bus1.step_up), 0);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(HOLD);
        checkOutput("after reprime pending", q1.size(), 0);
        checkOutput("after reprime step_up", int'(bus1.step_up), 1);

        tick(5);
        checkOutput("res4 leftover", q4.size(), 0);
        checkOutput("res1 leftover", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
